// File: rtl/mmio_master_if.sv
// CPU-side request/response and MMIO responder bus signals for mmio_master.
// No storage here; timing is defined entirely by mmio_master.
// master modport is the initiator's view, slave is the CPU + responders' view.
interface mmio_master_if;
    logic        cpu_req_valid;
    logic        cpu_req_we;
    logic [31:0] cpu_req_addr;
    logic [31:0] cpu_req_wdata;
    logic        cpu_busy;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_rdata;
    logic        cpu_resp_err;
    logic        mmio_read;
    logic        mmio_write;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_write_data;
    logic        mmio_work_in;
    logic        mmio_done_in;
    logic [31:0] mmio_read_data_in;

    modport master (
        input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
        output cpu_busy, cpu_resp_valid, cpu_resp_rdata, cpu_resp_err,
        output mmio_read, mmio_write, mmio_addr, mmio_write_data,
        input  mmio_work_in, mmio_done_in, mmio_read_data_in
    );

    modport slave (
        output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
        input  cpu_busy, cpu_resp_valid, cpu_resp_rdata, cpu_resp_err,
        input  mmio_read, mmio_write, mmio_addr, mmio_write_data,
        output mmio_work_in, mmio_done_in, mmio_read_data_in
    );
endinterface

// File: rtl/mmio_master.sv
// Single-outstanding MMIO initiator: CPU word request -> shared MMIO bus -> one-cycle response.
// Latency: bus request 1 cycle after accept, response 1 cycle after done/decode error; misaligned 1 cycle.
// Backpressure: cpu_busy high while not IDLE, requests during busy are dropped; MMIO_TIMEOUT_EN adds bus timeout.
module mmio_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         sys_clk,
    input  logic         rst_n,
    mmio_master_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_fin;
    logic        w_fin_err;
    logic [31:0] w_fin_rdata;
    logic        w_tmo;

`ifdef MMIO_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    // Counter holds (BUS cycle number - 1), so the last allowed cycle sees TIMEOUT_CYCLES-1.
    logic [CW-1:0] r_tmo_cnt;

    assign w_tmo = (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Timeout counter: cleared when a bus request is accepted, counts every BUS cycle.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (w_accept) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_BUS) begin
            r_tmo_cnt <= r_tmo_cnt + CW'(1);
        end
    end
`else
    logic w_unused_tmo;

    assign w_tmo        = 1'b0;
    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

    // State register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the completion status to be presented in RESP.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_fin       = 1'b0;
        w_fin_err   = 1'b0;
        w_fin_rdata = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.cpu_req_valid) begin
                    if (bus.cpu_req_addr[1:0] != 2'b00) begin
                        // Misaligned: answer with an error without touching the bus.
                        w_fin       = 1'b1;
                        w_fin_err   = 1'b1;
                        w_state_nxt = S_RESP;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_BUS;
                    end
                end
            end
            S_BUS: begin
                if (!bus.mmio_work_in) begin
                    // Nobody claimed the address.
                    w_fin       = 1'b1;
                    w_fin_err   = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (bus.mmio_done_in) begin
                    // Done beats a timeout landing in the same cycle.
                    w_fin       = 1'b1;
                    w_fin_rdata = r_we ? 32'h0 : bus.mmio_read_data_in;
                    w_state_nxt = S_RESP;
                end else if (w_tmo) begin
                    w_fin       = 1'b1;
                    w_fin_err   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                // Also the idle gap that lets the responder's done self-clear.
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Request/response holding registers; everything returns to 0 as RESP is left.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= bus.cpu_req_we;
                r_addr  <= bus.cpu_req_addr;
                r_wdata <= bus.cpu_req_we ? bus.cpu_req_wdata : 32'h0;
            end else if (r_state == S_RESP) begin
                r_we    <= 1'b0;
                r_addr  <= '0;
                r_wdata <= '0;
            end
            if (w_fin) begin
                r_err   <= w_fin_err;
                r_rdata <= w_fin_rdata;
            end else if (r_state == S_RESP) begin
                r_err   <= 1'b0;
                r_rdata <= '0;
            end
        end
    end

    assign bus.cpu_busy        = (r_state != S_IDLE);
    assign bus.cpu_resp_valid  = (r_state == S_RESP);
    assign bus.cpu_resp_rdata  = r_rdata;
    assign bus.cpu_resp_err    = r_err;
    assign bus.mmio_read       = (r_state == S_BUS) && !r_we;
    assign bus.mmio_write      = (r_state == S_BUS) && r_we;
    assign bus.mmio_addr       = r_addr;
    assign bus.mmio_write_data = r_wdata;

endmodule
